adc_sample_sequencer: RTL and testbench

Sequences the ADS7883-style serial ADC. It schedules conversions at a fixed sample rate, generates the chip-select and serial clock, and shifts in the leading zero plus WIDTH data bits. Each result is presented on a valid/ready stream to the downstream FFT/waterfall datapath. The block sits between the ADC pins and the sample consumer and owns all ADC timing.

---
 rtl/adc_seq_pkg.sv | 27 ++
 rtl/adc_rate_timer.sv | 35 +++
 rtl/adc_sample_sequencer.sv | 171 +++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_seq_pkg : shared types, defaults and frame-length helper for the ADC
//               sample sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
package adc_seq_pkg;

  localparam int c_width         = 12;
  localparam int c_half_div      = 2;
  localparam int c_quiet         = 4;
  localparam int c_sample_period = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_QUIET    = 3'd4
  } seq_state_t;

  // Clock cycles from the tick cycle until the FSM is back in IDLE.
  function automatic int frame_len(input int width, input int half_div, input int quiet);
    return 1 + half_div + 2 * half_div * (width + 1) + quiet;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_rate_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_rate_timer : conversion tick generator; counter holds at zero while
//                  disabled.  Rev 1.0
// ----------------------------------------------------------------------------
module adc_rate_timer
  import adc_seq_pkg::*;
#(
  parameter int SAMPLE_PERIOD = c_sample_period
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int                 c_cnt_w = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SAMPLE_PERIOD - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!enable || (r_count == c_last)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign tick = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/adc_sample_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_sample_sequencer : ADS7883-style serial ADC frame sequencer with a
//                        valid/ready sample stream.  Rev 1.0
// ----------------------------------------------------------------------------
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int WIDTH         = c_width,
  parameter int HALF_DIV      = c_half_div,
  parameter int QUIET         = c_quiet,
  parameter int SAMPLE_PERIOD = c_sample_period,
  parameter bit STRICT_PERIOD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  input  logic             adc_sd,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic             overrun,
  output logic             missed_tick,
  input  logic             status_clear
);

  localparam int c_cnt_max = (HALF_DIV > QUIET) ? HALF_DIV : QUIET;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_bit_w   = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_half_last  = c_cnt_w'(HALF_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_quiet_last = c_cnt_w'(QUIET - 1);
  localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(WIDTH);

  generate
    if (HALF_DIV < 1 || QUIET < 1) begin : g_bad_timing
      $error("adc_sample_sequencer: HALF_DIV and QUIET must be >= 1");
    end
    // Overlapping periods are only legal when deliberately relaxed; missed_tick then reports them.
    if (STRICT_PERIOD && (SAMPLE_PERIOD < frame_len(WIDTH, HALF_DIV, QUIET))) begin : g_bad_period
      $error("adc_sample_sequencer: SAMPLE_PERIOD shorter than one frame");
    end
  endgenerate

  seq_state_t         r_state;
  logic [c_cnt_w-1:0] r_half;
  logic [c_bit_w-1:0] r_bit;
  logic [WIDTH-1:0]   r_shift;
  logic               w_tick;
  logic               w_half_done;
  logic               w_load;

  adc_rate_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_rate_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (w_tick)
  );

  assign w_half_done = (r_half == c_half_last);
  assign w_load      = (r_state == S_SHIFT_HI) && w_half_done && (r_bit == c_bit_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_half   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state  <= S_SETUP;
            r_half   <= '0;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_half_done) begin
            r_state  <= S_SHIFT_LO;
            r_half   <= '0;
            r_bit    <= '0;
            adc_sclk <= 1'b0;
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        S_SHIFT_LO: begin
          if (w_half_done) begin
            // The leading zero eventually falls off the top of the WIDTH-bit register.
            r_state  <= S_SHIFT_HI;
            r_half   <= '0;
            adc_sclk <= 1'b1;
            r_shift  <= WIDTH'({r_shift, adc_sd});
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        S_SHIFT_HI: begin
          if (w_half_done) begin
            r_half <= '0;
            if (r_bit == c_bit_last) begin
              r_state  <= S_QUIET;
              adc_cs_n <= 1'b1;
            end else begin
              r_state  <= S_SHIFT_LO;
              r_bit    <= r_bit + c_bit_w'(1);
              adc_sclk <= 1'b0;
            end
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        S_QUIET: begin
          if (r_half == c_quiet_last) begin
            r_state <= S_IDLE;
            r_half  <= '0;
            busy    <= 1'b0;
          end else begin
            r_half <= r_half + c_cnt_w'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_half   <= '0;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      missed_tick  <= 1'b0;
    end else begin
      if (w_load) begin
        sample_data  <= r_shift;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (w_load && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (status_clear) begin
        overrun <= 1'b0;
      end

      if (w_tick && (r_state != S_IDLE)) begin
        missed_tick <= 1'b1;
      end else if (status_clear) begin
        missed_tick <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adc_sample_sequencer : ADC pin model plus sample scoreboard for the
//                           sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_adc_sample_sequencer;
  import adc_seq_pkg::*;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         adc_sd = 1'b0;
  logic         sample_ready = 1'b1;
  logic         status_clear = 1'b0;
  logic         adc_cs_n, adc_sclk, sample_valid, busy, overrun, missed_tick;
  logic [W-1:0] sample_data;

  logic         enable2 = 1'b0;
  logic         sd2 = 1'b0;
  logic         ready2 = 1'b1;
  logic         clear2 = 1'b0;
  logic         cs2_n, sclk2, valid2, busy2, overrun2, missed2;
  logic [W-1:0] data2;

  adc_sample_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sd(adc_sd),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .overrun(overrun), .missed_tick(missed_tick), .status_clear(status_clear)
  );

  adc_sample_sequencer #(.SAMPLE_PERIOD(40), .STRICT_PERIOD(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2),
    .adc_cs_n(cs2_n), .adc_sclk(sclk2), .adc_sd(sd2),
    .sample_data(data2), .sample_valid(valid2), .sample_ready(ready2),
    .busy(busy2), .overrun(overrun2), .missed_tick(missed2), .status_clear(clear2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC pin model: leading zero after the first falling sclk, then the word MSB first.
  logic [W-1:0] adc_words[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_word;
  logic [W-1:0] dropped;
  logic         exp_overrun = 1'b0;
  int           nbits = 0;
  int           frames_done = 0;
  int           pops = 0;
  int           cs2_falls = 0;

  always @(negedge adc_cs_n) begin
    if (adc_words.size() > 0) cur_word = adc_words.pop_front();
    else cur_word = W'($urandom);
    nbits  = 0;
    adc_sd = 1'b0;
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      adc_sd = (nbits == 0) ? 1'b0 : cur_word[W-nbits];
      nbits++;
    end
  end

  // A complete frame replaces any sample the consumer has not yet taken.
  always @(posedge adc_cs_n) begin
    if (rst_n && nbits == W + 1) begin
      if (exp_q.size() > 0) begin
        dropped     = exp_q.pop_front();
        exp_overrun = 1'b1;
      end
      exp_q.push_back(cur_word);
      frames_done++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got 0x%0h, expected no transfer", sample_data);
      end else begin
        check("sample_data", sample_data, exp_q.pop_front());
      end
      pops++;
    end
  end

  always @(negedge cs2_n) cs2_falls++;

  task automatic wait_frames(input int target, input int budget, input bit rnd);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(posedge clk); #1;
      if (rnd) sample_ready = ($urandom_range(0, 39) == 0);
      k++;
    end
    if (frames_done < target) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_done, target);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, k, p0, tgt;

    step(3);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_missed", missed_tick, 0);
    check("rst_data", sample_data, 0);
    rst_n = 1'b1;

    repeat (200) begin
      @(negedge clk);
      check("idle_pins", {adc_cs_n, adc_sclk, sample_valid, busy}, 4'b1100);
    end

    // Single conversion and its timing.
    adc_words.push_back(12'h44C);
    @(posedge clk); #1;
    e0 = cyc;
    enable = 1'b1;
    k = 0;
    while (adc_cs_n && k < 200) begin @(negedge clk); k++; end
    check("cs_low_cycle", cyc - e0, 64);
    k = 0;
    while (!sample_valid && k < 200) begin @(negedge clk); k++; end
    check("valid_cycle", cyc - e0, 118);
    check("sclk_falls", nbits, 13);
    @(negedge clk);
    check("valid_pulse", sample_valid, 0);

    // Alternating data, continuous running.
    step(1);
    adc_words.push_back(12'h44C); adc_words.push_back(12'h384);
    adc_words.push_back(12'h44C); adc_words.push_back(12'h384);
    wait_frames(frames_done + 4, 400, 1'b0);
    step(2);
    check("alt_overrun", overrun, 0);
    check("alt_missed", missed_tick, 0);
    check("alt_drained", exp_q.size(), 0);

    // Backpressure across two frames.
    sample_ready = 1'b0;
    adc_words.push_back(12'h44C); adc_words.push_back(12'h384);
    tgt = frames_done + 1;
    wait_frames(tgt, 200, 1'b0);
    step(3);
    check("bp_hold_data", sample_data, 12'h44C);
    check("bp_hold_valid", sample_valid, 1);
    check("bp_no_overrun_yet", overrun, 0);
    wait_frames(tgt + 1, 200, 1'b0);
    enable = 1'b0;
    check("bp_overwrite_data", sample_data, 12'h384);
    check("bp_overrun", overrun, 1);
    step(5);
    p0 = pops;
    sample_ready = 1'b1;
    step(5);
    check("bp_one_transfer", pops - p0, 1);
    check("bp_valid_drop", sample_valid, 0);
    status_clear = 1'b1;
    step(1);
    status_clear = 1'b0;
    exp_overrun = 1'b0;
    check("bp_clear", overrun, 0);

    // Random data and random consumer stalls.
    enable = 1'b1;
    wait_frames(frames_done + 8, 8 * 64 + 200, 1'b1);
    enable = 1'b0;
    sample_ready = 1'b1;
    step(80);
    check("rand_overrun", overrun, exp_overrun);
    check("rand_missed", missed_tick, 0);
    check("rand_drained", exp_q.size(), 0);
    status_clear = 1'b1;
    step(1);
    status_clear = 1'b0;
    exp_overrun = 1'b0;

    // Reset in the middle of bit 6.
    adc_words.push_back(12'h5A5);
    enable = 1'b1;
    k = 0;
    while (!(nbits == 7 && !adc_cs_n) && k < 300) begin @(negedge clk); k++; end
    check("mid_reached_bit6", nbits, 7);
    rst_n = 1'b0;
    #1;
    check("mid_cs_n", adc_cs_n, 1);
    check("mid_sclk", adc_sclk, 1);
    check("mid_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_valid", sample_valid, 0);
    end
    rst_n = 1'b1;
    adc_words.push_back(12'hA5A);
    p0 = pops;
    wait_frames(frames_done + 1, 200, 1'b0);
    enable = 1'b0;
    step(3);
    check("mid_recovered", pops - p0, 1);
    check("mid_overrun", overrun, 0);

    // Sample period shorter than a frame on the second instance.
    @(posedge clk); #1;
    e0 = cyc;
    enable2 = 1'b1;
    repeat (126) begin
      @(negedge clk);
      if (cyc - e0 == 79) check("mt_before", missed2, 0);
      if (cyc - e0 == 80) check("mt_after", missed2, 1);
      if (cyc - e0 == 119) check("mt_no_restart", cs2_falls, 1);
    end
    check("mt_next_frame", cs2_falls, 2);
    enable2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
